// File: rtl/key_event_dispatcher_if.sv
// Keyboard-event / player-port bundle for key_event_dispatcher.
// master = keyboard driver and player logic side, slave = dispatcher side.
interface key_event_dispatcher_if;
  logic       valid;
  logic       makeBreak;
  logic [7:0] outCode;

  logic       p0_valid;
  logic       p0_make;
  logic [7:0] p0_code;
  logic       p0_ready;

  logic       p1_valid;
  logic       p1_make;
  logic [7:0] p1_code;
  logic       p1_ready;

  logic       fifo_full;
  logic       drop_pulse;
  logic [7:0] drop_count;

  modport master (
    output valid, makeBreak, outCode, p0_ready, p1_ready,
    input  p0_valid, p0_make, p0_code,
    input  p1_valid, p1_make, p1_code,
    input  fifo_full, drop_pulse, drop_count
  );

  modport slave (
    input  valid, makeBreak, outCode, p0_ready, p1_ready,
    output p0_valid, p0_make, p0_code,
    output p1_valid, p1_make, p1_code,
    output fifo_full, drop_pulse, drop_count
  );
endinterface

// File: rtl/key_event_dispatcher.sv
// Queues PS/2 make/break events and routes them to player 0, player 1, or both.
// Optional KEY_DISPATCH_DROP_CNT_EN builds a saturating overflow counter on drop_count.
module key_event_dispatcher #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  key_event_dispatcher_if.slave   bus
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic {IDLE, SERVE} state_t;

  state_t        state;
  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    pend;
  logic [7:0]    ocode;
  logic          omake;

  logic [1:0]    owner;
  logic          mapped;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [1:0]    pend_next;
  logic [10:0]   head;

  // Owner mask: bit 0 = player 0 (W/A/S/D), bit 1 = player 1 (arrows); 00 means not ours.
  always_comb begin
    owner = 2'b00;
    if (bus.valid) begin
      case (bus.outCode)
        8'h1D, 8'h1C, 8'h1B, 8'h23: owner = 2'b01;
        8'h75, 8'h6B, 8'h72, 8'h74: owner = 2'b10;
        8'h29:                      owner = 2'b11;
        default:                    owner = 2'b00;
      endcase
    end
  end

  assign mapped    = (owner != 2'b00);
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign push      = mapped && !full;
  assign pend_next = pend & ~{bus.p1_ready, bus.p0_ready};
  assign pop       = !empty && ((state == IDLE) || (pend_next == 2'b00));
  assign head      = mem[rd_ptr];

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem[wr_ptr] <= {owner, bus.makeBreak, bus.outCode};
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A completing entry hands over to the next queued one on the same edge, so no bubble.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      pend  <= 2'b00;
      ocode <= 8'h00;
      omake <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            pend  <= head[10:9];
            omake <= head[8];
            ocode <= head[7:0];
            state <= SERVE;
          end
        end
        SERVE: begin
          if (pop) begin
            pend  <= head[10:9];
            omake <= head[8];
            ocode <= head[7:0];
          end else begin
            pend <= pend_next;
            if (pend_next == 2'b00) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.p0_valid   = pend[0];
  assign bus.p1_valid   = pend[1];
  assign bus.p0_code    = ocode;
  assign bus.p1_code    = ocode;
  assign bus.p0_make    = omake;
  assign bus.p1_make    = omake;
  assign bus.fifo_full  = full;
  assign bus.drop_pulse = mapped && full && !reset;

`ifdef KEY_DISPATCH_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      drop_cnt_q <= 8'h00;
    end else if (bus.drop_pulse && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'h01;
    end
  end

  assign bus.drop_count = drop_cnt_q;
`else
  assign bus.drop_count = 8'h00;
`endif

endmodule
